// File: rtl/clk_monitor_pkg.sv
// rtl/clk_monitor_pkg.sv - shared types, widths and tolerance helper for the clock monitor
package clk_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int             CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    // True when an unsigned 8-bit measurement lies within +/- tol of the expected value
    function automatic logic within_tol(input logic [CNT_W-1:0] val,
                                        input logic signed [8:0] expected,
                                        input logic signed [8:0] tol);
        logic signed [8:0] diff;
        diff = $signed({1'b0, val}) - expected;
        return (diff <= tol) && (diff >= -tol);
    endfunction

endpackage

// File: rtl/clk_monitor_edge.sv
// rtl/clk_monitor_edge.sv - div_in sampling and edge strobes; CLK_MONITOR_SYNC_EN adds a 2-flop synchronizer
module clk_monitor_edge (
    input  logic clk,
    input  logic rst,
    input  logic div_in,
    output logic level,
    output logic rise_stb,
    output logic fall_stb
);

    logic s_in;
    logic s0;
    logic prev;

`ifdef CLK_MONITOR_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchronizer so an asynchronous div_in can be monitored
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= div_in;
            sync2 <= sync1;
        end
    end

    assign s_in = sync2;
`else
    assign s_in = div_in;
`endif

    // Sample the (possibly synchronized) input and keep the previous sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s0   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s0   <= s_in;
            prev <= s0;
        end
    end

    assign level    = s0;
    assign rise_stb = s0 & ~prev;
    assign fall_stb = ~s0 & prev;

endmodule

// File: rtl/clk_monitor.sv
// rtl/clk_monitor.sv - period/high-time measurement and lock FSM for a divided clock (CLK_MONITOR_SYNC_EN selects synchronized input)
module clk_monitor
    import clk_monitor_pkg::*;
#(
    parameter int EXP_PERIOD = 27,
    parameter int EXP_HIGH   = 14,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       div_in,
    output logic       rise_stb,
    output logic       fall_stb,
    output logic       locked,
    output logic       err,
    output logic [7:0] period_out,
    output logic [7:0] high_out
);

    localparam logic signed [8:0] EXP_P_S = 9'(EXP_PERIOD);
    localparam logic signed [8:0] EXP_H_S = 9'(EXP_HIGH);
    localparam logic signed [8:0] TOL_S   = 9'(TOL);
    localparam logic [CNT_W-1:0]  LOCK_V  = CNT_W'(LOCK_CNT);

    logic             level;
    state_t           state;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] match_nxt;
    logic             fall_seen;
    logic             period_match;
    logic             timeout;

    clk_monitor_edge u_edge (
        .clk      (clk),
        .rst      (rst),
        .div_in   (div_in),
        .level    (level),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // A closing period matches only if it did not saturate and a fall was seen inside it
    always_comb begin
        period_match = within_tol(per_cnt, EXP_P_S, TOL_S)
                     & within_tol(high_out, EXP_H_S, TOL_S)
                     & fall_seen
                     & (per_cnt != CNT_MAX);
        timeout      = (per_cnt == CNT_MAX) & ~rise_stb;
        match_nxt    = match_cnt + 8'd1;
    end

    // Period and high-time counters with their captured results
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt    <= '0;
            hi_cnt     <= '0;
            period_out <= '0;
            high_out   <= '0;
            fall_seen  <= 1'b0;
        end else begin
            if (rise_stb) begin
                per_cnt    <= 8'd1;
                hi_cnt     <= 8'd1;
                period_out <= per_cnt;
                fall_seen  <= 1'b0;
            end else begin
                if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 8'd1;
                if (level && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 8'd1;
            end
            if (fall_stb) begin
                high_out  <= hi_cnt;
                fall_seen <= 1'b1;
            end
        end
    end

    // Lock FSM: judge each period on the rise that closes it, drop to IDLE on timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            match_cnt <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise_stb) begin
                        state     <= MEASURE;
                        match_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (rise_stb) begin
                        if (period_match) begin
                            match_cnt <= match_nxt;
                            if (match_nxt == LOCK_V) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (rise_stb) begin
                        if (!period_match) begin
                            state     <= MEASURE;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                            err       <= 1'b1;
                        end
                    end else if (timeout) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_monitor.sv
// tb/tb_clk_monitor.sv - randomized self-checking bench for clk_monitor (TOL=0 and TOL=1 instances)
module tb_clk_monitor;

`ifdef CLK_MONITOR_SYNC_EN
    localparam int SLAT = 3;
`else
    localparam int SLAT = 1;
`endif
    localparam int EXP_P = 27;
    localparam int EXP_H = 14;
    localparam int LOCKN = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            div_in = 1'b0;
    logic [1:0]      rs;
    logic [1:0]      fs;
    logic [1:0]      lk;
    logic [1:0]      er;
    logic [1:0][7:0] po;
    logic [1:0][7:0] ho;

    int checks = 0;
    int errors = 0;
    int err_cnt [2] = '{0, 0};

    int m_active [2];
    int m_locked [2];
    int m_cnt    [2];
    int m_err    [2];
    int prev_p = 0;
    int prev_h = 0;
    int chk    = 0;

    clk_monitor #(.EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .TOL(0), .LOCK_CNT(LOCKN)) dut0 (
        .clk(clk), .rst(rst), .div_in(div_in), .rise_stb(rs[0]), .fall_stb(fs[0]),
        .locked(lk[0]), .err(er[0]), .period_out(po[0]), .high_out(ho[0])
    );

    clk_monitor #(.EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .TOL(1), .LOCK_CNT(LOCKN)) dut1 (
        .clk(clk), .rst(rst), .div_in(div_in), .rise_stb(rs[1]), .fall_stb(fs[1]),
        .locked(lk[1]), .err(er[1]), .period_out(po[1]), .high_out(ho[1])
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (er[0]) err_cnt[0] <= err_cnt[0] + 1;
        if (er[1]) err_cnt[1] <= err_cnt[1] + 1;
    end

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Period-level reference: each rise judges the period that just ended
    task automatic model_rise();
        int good;
        for (int i = 0; i < 2; i++) begin
            if (m_active[i] != 0 && prev_p > 255) begin
                m_err[i]++;
                m_locked[i] = 0;
                m_active[i] = 0;
            end
            if (m_active[i] == 0) begin
                m_active[i] = 1;
                m_cnt[i]    = 0;
            end else begin
                good = (prev_p < 255 && prev_h > 0 &&
                        iabs(prev_p - EXP_P) <= i && iabs(prev_h - EXP_H) <= i) ? 1 : 0;
                if (m_locked[i] != 0) begin
                    if (good == 0) begin
                        m_err[i]++;
                        m_locked[i] = 0;
                        m_cnt[i]    = 0;
                    end
                end else if (good != 0) begin
                    m_cnt[i]++;
                    if (m_cnt[i] >= LOCKN) m_locked[i] = 1;
                end else begin
                    m_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0;
            m_locked[i] = 0;
            m_cnt[i]    = 0;
        end
        prev_p = 0;
        prev_h = 0;
        chk    = 0;
    endtask

    task automatic do_rise();
        int exp_po;
        exp_po = (prev_p > 255) ? 255 : prev_p;
        model_rise();
        div_in = 1'b1;
        repeat (SLAT) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rs[i] !== 1'b1) begin
                errors++;
                $display("FAIL rise_latency dut%0d got %b exp 1 at %0t", i, rs[i], $time);
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rs[i] !== 1'b0) begin
                errors++;
                $display("FAIL rise_width dut%0d got %b exp 0", i, rs[i]);
            end
            if (chk != 0) begin
                checks++;
                if (po[i] !== exp_po[7:0]) begin
                    errors++;
                    $display("FAIL period_out dut%0d got %0d exp %0d", i, po[i], exp_po);
                end
                checks++;
                if (ho[i] !== prev_h[7:0]) begin
                    errors++;
                    $display("FAIL high_out dut%0d got %0d exp %0d", i, ho[i], prev_h);
                end
            end
            checks++;
            if (lk[i] !== m_locked[i][0]) begin
                errors++;
                $display("FAIL locked dut%0d got %b exp %0d at %0t", i, lk[i], m_locked[i], $time);
            end
            checks++;
            if (err_cnt[i] !== m_err[i]) begin
                errors++;
                $display("FAIL err_count dut%0d got %0d exp %0d at %0t", i, err_cnt[i], m_err[i], $time);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_fall();
        div_in = 1'b0;
        repeat (SLAT) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (fs[i] !== 1'b1) begin
                errors++;
                $display("FAIL fall_latency dut%0d got %b exp 1", i, fs[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int p, input int h);
        do_rise();
        wait_cyc(h - SLAT - 2);
        do_fall();
        wait_cyc(p - h - SLAT - 1);
        prev_p = p;
        prev_h = h;
        chk    = 1;
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({rs[i], fs[i], lk[i], er[i], po[i], ho[i]} !== 20'd0) begin
                errors++;
                $display("FAIL %s dut%0d got rs=%b fs=%b lk=%b er=%b po=%0d ho=%0d exp all 0",
                         tag, i, rs[i], fs[i], lk[i], er[i], po[i], ho[i]);
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 2; i++) m_err[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_lock();
        repeat (6) drive_period(EXP_P, EXP_H);
    endtask

    task automatic test_stretch();
        drive_period(28, EXP_H);
        repeat (5) drive_period(EXP_P, EXP_H);
    endtask

    task automatic test_sat_period();
        drive_period(255, EXP_H);
        repeat (5) drive_period(EXP_P, EXP_H);
    endtask

    task automatic test_timeout();
        int exp_err;
        do_rise();
        wait_cyc(EXP_H - SLAT - 2);
        do_fall();
        wait_cyc(300 - SLAT - 1);
        for (int i = 0; i < 2; i++) begin
            exp_err = m_err[i] + ((m_active[i] != 0) ? 1 : 0);
            checks++;
            if (lk[i] !== 1'b0 || err_cnt[i] !== exp_err) begin
                errors++;
                $display("FAIL timeout dut%0d got locked=%b errs=%0d exp locked=0 errs=%0d",
                         i, lk[i], err_cnt[i], exp_err);
            end
        end
        prev_p = EXP_H + 300;
        prev_h = EXP_H;
        chk    = 1;
        repeat (6) drive_period(EXP_P, EXP_H);
    endtask

    task automatic test_tolerance();
        for (int k = 0; k < 8; k++) drive_period((k % 2 == 0) ? 26 : 28, EXP_H);
        drive_period(29, EXP_H);
        repeat (5) drive_period(EXP_P, EXP_H);
    endtask

    task automatic test_reset_mid();
        do_rise();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_mid");
        @(posedge clk);
        #1;
        model_reset();
        model_rise();
        wait_cyc(6);
        div_in = 1'b0;
        wait_cyc(13);
        repeat (6) drive_period(EXP_P, EXP_H);
    endtask

    task automatic test_random();
        int p;
        int h;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(9, 0) < 7) begin
                p = EXP_P;
                h = EXP_H;
            end else begin
                p = $urandom_range(30, 24);
                h = $urandom_range(16, 12);
            end
            drive_period(p, h);
        end
        drive_period(EXP_P, EXP_H);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stretch();
        test_sat_period();
        test_timeout();
        test_tolerance();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 Parameter EXP_PERIOD, default 27: expected div_in period in clk cycles.
REQ-002 Parameter EXP_HIGH, default 14: expected div_in high time in clk cycles.
REQ-003 Parameter TOL, default 0: allowed +/- deviation for period and high time.
REQ-004 Parameter LOCK_CNT, default 4: consecutive matching periods needed to lock.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 div_in  input  1  divided clock to monitor; the clock-divider output, or an external slow clock.
REQ-008 rise_stb  output  1  one-cycle pulse per detected div_in rising edge.
REQ-009 fall_stb  output  1  one-cycle pulse per detected div_in falling edge.
REQ-010 locked  output  1  high while div_in matches expected period and high time.
REQ-011 err  output  1  one-cycle pulse on loss of lock or timeout.
REQ-012 period_out  output  8  last measured period, in clk cycles.
REQ-013 high_out  output  8  last measured high time, in clk cycles.

Function
REQ-014 Sampling: div_in registered into s0, then prev; rise_stb = s0 & ~prev, fall_stb = ~s0 & prev.
- Result: rise_stb is high in the cycle after the clk edge that first captures div_in=1 (1-cycle latency, no macro).
REQ-015 per_cnt (8 bit) resets to 1 in the cycle of rise_stb and otherwise increments, saturating at 255.
REQ-016 On rise_stb, period_out shall load per_cnt; a steady 27-cycle input yields 27.
REQ-017 hi_cnt (8 bit) resets to 1 on rise_stb and increments while s0=1, saturating at 255.
- On fall_stb, high_out shall load hi_cnt; the default waveform yields 14.
REQ-018 A period matches when:
- |period - EXP_PERIOD| <= TOL, and
- |high_out - EXP_HIGH| <= TOL, with high_out taken from the fall within that period.
- All comparisons use 9-bit signed arithmetic.
REQ-019 FSM states: IDLE, MEASURE, LOCKED. Reset state is IDLE.
REQ-020 IDLE: on the first rise_stb, go to MEASURE and clear match_cnt; no comparison is made.
REQ-021 MEASURE, on each rise_stb:
- match: match_cnt+1;
- mismatch: clear match_cnt, no err.
- When match_cnt reaches LOCK_CNT, go to LOCKED and assert locked in the next cycle.
REQ-022 LOCKED, on a mismatching rise_stb: pulse err, deassert locked, go to MEASURE with match_cnt=0.
REQ-023 Timeout: per_cnt reaching 255 with no rise_stb in MEASURE or LOCKED shall:
- go to IDLE;
- deassert locked;
- pulse err once.
- A stuck-high or stuck-low div_in therefore times out.
REQ-024 rise_stb in the same cycle as per_cnt=255: treat as a mismatching period (period_out=255), not a timeout.
REQ-025 A period with no fall_stb (high_out stale) counts as a mismatch.

Reset
REQ-026 rst values:
- s0, prev, sync flops = 0;
- per_cnt, hi_cnt, match_cnt = 0;
- period_out, high_out = 0;
- rise_stb, fall_stb, locked, err = 0;
- state = IDLE.
REQ-027 rst mid-operation overrides all other events in that cycle.
- After release, the first div_in rise is treated as a first edge, with no comparison and no err.

Configuration
REQ-028 With CLK_MONITOR_SYNC_EN defined:
- div_in passes through a 2-flop synchronizer before s0 (asynchronous div_in supported);
- rise_stb/fall_stb latency becomes 3 cycles;
- measured values are unchanged.
REQ-029 Without CLK_MONITOR_SYNC_EN: div_in is sampled directly into s0 and must be synchronous to clk.

Structure
REQ-030 Package clk_monitor_pkg shall hold:
- the FSM state enum (IDLE/MEASURE/LOCKED);
- CNT_W=8;
- CNT_MAX=255.
REQ-031 Sub-module clk_monitor_edge shall hold the optional synchronizer, s0/prev and the rise/fall strobes; counters and FSM stay in clk_monitor.

Verification
REQ-032 Default params, divider waveform (period 27, high 14) for 6 periods.
- period_out=27, high_out=14;
- locked rises after the 5th rise_stb;
- err never pulses.
REQ-033 Locked, then one period stretched to 28 cycles -> err pulses once, locked falls, relock after 4 further good periods.
REQ-034 Locked, then div_in held low for 300 cycles -> at per_cnt=255: err pulses once, state IDLE, locked=0.
REQ-035 rst asserted for 1 cycle mid-high-phase while locked -> all outputs 0 the next cycle; the first rise after reset gives no err.
REQ-036 TOL=1, alternating periods of 26 and 28 (high 14) -> locks; period of 29 -> err.
REQ-037 With CLK_MONITOR_SYNC_EN, repeat REQ-032 -> identical measurements; rise_stb appears 3 cycles after the div_in edge.
